// File: rtl/ysyx_25060170_ifu_pkg.sv
// IFU shared types: FSM state encoding, reset PC default, instruction width.
// Imported by ysyx_25060170_ifu.
package ysyx_25060170_ifu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_DELIVER = 2'd2,
    S_HALT    = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25060170_ifu.sv
// Instruction fetch unit: PC register, imem request/response FSM, IDU handshake.
// Define IFU_PERF_CNT_EN to add the perf_fetch_cnt / perf_stall_cnt outputs.
module ysyx_25060170_ifu
  import ysyx_25060170_ifu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] dnpc,
  input  logic              halt_i,
  output logic              fetch_err,
  output logic              halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  ifu_state_e        state;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] inst_q;
  logic              err_q;

  // Request is masked while rst is held so nothing escapes during reset.
  assign imem_req_valid = (state == S_FETCH) && !rst;
  assign imem_req_addr  = pc;
  assign inst_valid     = (state == S_DELIVER);
  assign halted         = (state == S_HALT);
  assign pc_o           = pc;
  assign inst_o         = inst_q;
  assign fetch_err      = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      pc     <= RESET_PC;
      inst_q <= '0;
      err_q  <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q <= imem_rsp_data;
            if (imem_rsp_err) begin
              err_q <= 1'b1;
              state <= S_HALT;
            end else begin
              state <= S_DELIVER;
            end
          end
        end
        S_DELIVER: begin
          if (inst_ready) begin
            if (halt_i) begin
              state <= S_HALT;
            end else begin
              pc    <= jump_en ? dnpc : pc + ADDR_W'(4);
              state <= S_FETCH;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic stall_cyc;

  assign stall_cyc = ((state == S_FETCH) && !imem_req_ready)
                  || ((state == S_WAIT) && !imem_rsp_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (inst_valid && inst_ready)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall_cyc)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Scoreboard bench for ysyx_25060170_ifu: directed fetch/jump/wrap/stall/halt/error.
// Perf counter checks compile in when IFU_PERF_CNT_EN is defined.
module tb_ysyx_25060170_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        jump_en;
  logic [31:0] dnpc;
  logic        halt_i;
  logic        fetch_err;
  logic        halted;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ysyx_25060170_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .pc_o           (pc_o),
    .inst_o         (inst_o),
    .jump_en        (jump_en),
    .dnpc           (dnpc),
    .halt_i         (halt_i),
    .fetch_err      (fetch_err),
    .halted         (halted)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;

  logic [31:0] exp_req[$];
  logic [63:0] exp_inst[$];

  int          stall_left = 0;
  int          iwait_left = 0;
  logic        err_next = 1'b0;
  logic        plan_jump = 1'b0;
  logic        plan_halt = 1'b0;
  logic [31:0] plan_dnpc = 32'h0;
  logic        mem_acc;
  logic [31:0] mem_a;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_inst_valid"}, 64'(inst_valid), 64'd0);
    chk({tag, "_inst_o"}, 64'(inst_o), 64'd0);
    chk({tag, "_pc_o"}, 64'(pc_o), 64'h8000_0000);
    chk({tag, "_req_addr"}, 64'(imem_req_addr), 64'h8000_0000);
    chk({tag, "_fetch_err"}, 64'(fetch_err), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
`ifdef IFU_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, 64'(perf_fetch_cnt), 64'd0);
    chk({tag, "_perf_stall"}, 64'(perf_stall_cnt), 64'd0);
`endif
  endtask

  task automatic wait_hs(input int n);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #2;
      if (hs_cnt >= n) break;
    end
    if (hs_cnt < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_hs%0d: got %0d handshakes, want %0d", n, hs_cnt, n);
    end
  endtask

  // Memory: single-cycle response after accept, optional ready stall
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      mem_acc = imem_req_valid && imem_req_ready && !rst;
      mem_a   = imem_req_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = mem_acc;
      imem_rsp_data  = mem_acc ? word(mem_a) : 32'h0;
      imem_rsp_err   = mem_acc && err_next;
      if (mem_acc) err_next = 1'b0;
      if (imem_req_valid && stall_left > 0) begin
        imem_req_ready = 1'b0;
        stall_left--;
      end else begin
        imem_req_ready = 1'b1;
      end
    end
  end

  // Consumer: planned redirect on DELIVER, junk redirect/halt otherwise
  initial begin
    inst_ready = 1'b1;
    jump_en    = 1'b0;
    dnpc       = 32'h0;
    halt_i     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (inst_valid) begin
        jump_en = plan_jump;
        dnpc    = plan_dnpc;
        halt_i  = plan_halt;
        if (iwait_left > 0) begin
          inst_ready = 1'b0;
          iwait_left--;
        end else begin
          inst_ready = 1'b1;
        end
      end else begin
        jump_en    = 1'b1;
        dnpc       = 32'hDEAD_BEE0;
        halt_i     = 1'b1;
        inst_ready = 1'b1;
      end
    end
  end

  // Monitor: pop and compare on each request and delivery handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) begin
        n_cmp++;
        if (exp_req.size() == 0) begin
          n_bad++;
          $display("FAIL req_unexpected: got addr %h, want no request",
                   imem_req_addr);
        end else begin
          logic [31:0] e;
          e = exp_req.pop_front();
          if (imem_req_addr !== e) begin
            n_bad++;
            $display("FAIL req_addr: got %h, want %h", imem_req_addr, e);
          end
        end
      end
      if (inst_valid && inst_ready) begin
        n_cmp++;
        hs_cnt++;
        if (exp_inst.size() == 0) begin
          n_bad++;
          $display("FAIL inst_unexpected: got %h/%h, want none", pc_o, inst_o);
        end else begin
          logic [63:0] e;
          e = exp_inst.pop_front();
          if ({pc_o, inst_o} !== e) begin
            n_bad++;
            $display("FAIL inst: got %h, want %h", {pc_o, inst_o}, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst0");

    exp_req.push_back(32'h8000_0000);
    exp_inst.push_back({32'h8000_0000, word(32'h8000_0000)});
    exp_req.push_back(32'h8000_0004);
    @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    chk("c1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c1_req_addr", 64'(imem_req_addr), 64'h8000_0000);
    @(negedge clk);
    chk("c2_req_valid", 64'(imem_req_valid), 64'd0);
    chk("c2_inst_valid", 64'(inst_valid), 64'd0);
    @(negedge clk);
    chk("c3_inst_valid", 64'(inst_valid), 64'd1);

    stall_left = 4;
    plan_jump  = 1'b1;
    plan_dnpc  = 32'h8000_0100;
    plan_halt  = 1'b0;
    exp_inst.push_back({32'h8000_0004, word(32'h8000_0004)});
    exp_req.push_back(32'h8000_0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), 64'(imem_req_valid), 64'd1);
      chk($sformatf("stall%0d_addr", i), 64'(imem_req_addr), 64'h8000_0004);
    end
    @(negedge clk);
    chk("post_stall_valid", 64'(imem_req_valid), 64'd0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_stall_4", 64'(perf_stall_cnt), 64'd4);
    chk("perf_fetch_1", 64'(perf_fetch_cnt), 64'd1);
`endif
    wait_hs(2);

    plan_jump = 1'b1;
    plan_dnpc = 32'hFFFF_FFFC;
    exp_inst.push_back({32'h8000_0100, word(32'h8000_0100)});
    exp_req.push_back(32'hFFFF_FFFC);
    wait_hs(3);

    plan_jump = 1'b0;
    exp_inst.push_back({32'hFFFF_FFFC, word(32'hFFFF_FFFC)});
    exp_req.push_back(32'h0000_0000);
    wait_hs(4);

    iwait_left = 3;
    plan_jump  = 1'b1;
    plan_dnpc  = 32'h8000_0300;
    plan_halt  = 1'b1;
    exp_inst.push_back({32'h0000_0000, word(32'h0000_0000)});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (inst_valid) break;
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("dhold%0d_valid", i), 64'(inst_valid), 64'd1);
      chk($sformatf("dhold%0d_pc", i), 64'(pc_o), 64'h0);
      chk($sformatf("dhold%0d_inst", i), 64'(inst_o), 64'(word(32'h0)));
    end
    wait_hs(5);
    repeat (3) @(negedge clk);
    chk("halt_halted", 64'(halted), 64'd1);
    chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
    chk("halt_inst_valid", 64'(inst_valid), 64'd0);
    chk("halt_pc", 64'(pc_o), 64'h0);
`ifdef IFU_PERF_CNT_EN
    chk("perf_fetch_5", 64'(perf_fetch_cnt), 64'd5);
`endif

    @(posedge clk);
    #2 rst = 1'b1;
    plan_jump = 1'b0;
    plan_halt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst1");

    exp_req.push_back(32'h8000_0000);
    err_next = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("err_fetch_err", 64'(fetch_err), 64'd1);
    chk("err_halted", 64'(halted), 64'd1);
    chk("err_req_valid", 64'(imem_req_valid), 64'd0);
    chk("err_inst_valid", 64'(inst_valid), 64'd0);

    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst2");
    chk("exp_req_empty", 64'(exp_req.size()), 64'd0);
    chk("exp_inst_empty", 64'(exp_inst.size()), 64'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
